// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, function codes, controller state codes and
// datapath select encodings used by the multicycle and single-cycle designs.
package mips_pkg;

  localparam logic [5:0] OpcRType = 6'h00;
  localparam logic [5:0] OpcJ     = 6'h02;
  localparam logic [5:0] OpcJal   = 6'h03;
  localparam logic [5:0] OpcBeq   = 6'h04;
  localparam logic [5:0] OpcAddi  = 6'h08;
  localparam logic [5:0] OpcSlti  = 6'h0A;
  localparam logic [5:0] OpcLw    = 6'h23;
  localparam logic [5:0] OpcSw    = 6'h2B;

  localparam logic [5:0] FuncJr  = 6'h08;
  localparam logic [5:0] FuncAdd = 6'h20;
  localparam logic [5:0] FuncSub = 6'h22;
  localparam logic [5:0] FuncAnd = 6'h24;
  localparam logic [5:0] FuncOr  = 6'h25;
  localparam logic [5:0] FuncSlt = 6'h2A;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExR     = 4'd2,
    StExI     = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbR     = 4'd7,
    StWbI     = 4'd8,
    StWbMem   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StErr     = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    AluAdd  = 2'd0,
    AluSub  = 2'd1,
    AluFunc = 2'd2,
    AluNop  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PcAluResult = 2'd0,
    PcAluOut    = 2'd1,
    PcJump      = 2'd2,
    PcReg       = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    SrcBReg    = 2'd0,
    SrcBFour   = 2'd1,
    SrcBImm    = 2'd2,
    SrcBImmSh2 = 2'd3
  } alu_src_b_e;

  typedef enum logic [3:0] {
    IcRArith  = 4'd0,
    IcSlt     = 4'd1,
    IcJr      = 4'd2,
    IcAddi    = 4'd3,
    IcSlti    = 4'd4,
    IcLw      = 4'd5,
    IcSw      = 4'd6,
    IcBeq     = 4'd7,
    IcJ       = 4'd8,
    IcJal     = 4'd9,
    IcIllegal = 4'd10
  } inst_class_e;

endpackage

// File: rtl/mips_inst_decoder.sv
// Combinational instruction classifier: opcode/func -> instruction class plus
// an illegal flag for anything outside the supported subset.
module mips_inst_decoder
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  output inst_class_e inst_class_o,
  output logic        illegal_o
);

  always_comb begin
    inst_class_o = IcIllegal;
    case (opcode_i)
      OpcRType: begin
        case (func_i)
          FuncAdd, FuncSub, FuncAnd, FuncOr: inst_class_o = IcRArith;
          FuncSlt:                           inst_class_o = IcSlt;
          FuncJr:                            inst_class_o = IcJr;
          default:                           inst_class_o = IcIllegal;
        endcase
      end
      OpcAddi: inst_class_o = IcAddi;
      OpcSlti: inst_class_o = IcSlti;
      OpcLw:   inst_class_o = IcLw;
      OpcSw:   inst_class_o = IcSw;
      OpcBeq:  inst_class_o = IcBeq;
      OpcJ:    inst_class_o = IcJ;
      OpcJal:  inst_class_o = IcJal;
      default: inst_class_o = IcIllegal;
    endcase
    illegal_o = (inst_class_o == IcIllegal);
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with a bounded memory-wait counter and a sticky
// error state entered on illegal instructions or memory timeouts.
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned INST_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              iord,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_dst,
  output logic              jal,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              slt,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [1:0]        pc_src,
  output logic              busy,
  output logic              err,
  output logic [3:0]        state
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  inst_class_e     inst_class;
  logic            illegal;
  logic            timeout;
  logic            unused_in;

  // Branch PC gating with zero happens in the datapath, not here.
  assign unused_in = ^{inst, zero};

  mips_inst_decoder u_decoder (
    .opcode_i     (inst[31:26]),
    .func_i       (inst[5:0]),
    .inst_class_o (inst_class),
    .illegal_o    (illegal)
  );

  // Ready in the final allowed wait cycle still completes the access.
  assign timeout = (wait_cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    jal           = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    slt           = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    alu_op        = AluAdd;
    pc_src        = PcAluResult;
    busy          = 1'b1;
    err           = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        pc_src    = PcAluOut;
        busy      = mem_ready;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
          if (timeout) state_d = StErr;
        end
      end
      StDecode: begin
        alu_src_b = SrcBImmSh2;
        if (illegal) begin
          state_d = StErr;
        end else begin
          case (inst_class)
            IcRArith, IcSlt:  state_d = StExR;
            IcAddi, IcSlti:   state_d = StExI;
            IcLw, IcSw:       state_d = StMemAddr;
            IcBeq:            state_d = StBranch;
            IcJ, IcJal, IcJr: state_d = StJump;
            default:          state_d = StErr;
          endcase
        end
      end
      StExR: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBReg;
        alu_op    = AluFunc;
        state_d   = StWbR;
      end
      StExI: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        alu_op    = (inst_class == IcSlti) ? AluSub : AluAdd;
        state_d   = StWbI;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (inst_class == IcLw) ? StMemRd : StMemWr;
      end
      StMemRd, StMemWr: begin
        iord      = 1'b1;
        mem_read  = (state_q == StMemRd);
        mem_write = (state_q == StMemWr);
        if (mem_ready) begin
          state_d = (state_q == StMemRd) ? StWbMem : StFetch;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
          if (timeout) state_d = StErr;
        end
      end
      StWbR: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        slt       = (inst_class == IcSlt);
        state_d   = StFetch;
      end
      StWbI: begin
        reg_write = 1'b1;
        slt       = (inst_class == IcSlti);
        state_d   = StFetch;
      end
      StWbMem: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SrcBReg;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_src        = PcAluResult;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_src    = (inst_class == IcJr) ? PcReg : PcJump;
        jal       = (inst_class == IcJal);
        reg_write = (inst_class == IcJal);
        state_d   = StFetch;
      end
      StErr: begin
        err     = 1'b1;
        state_d = StErr;
      end
      default: begin
        err     = 1'b1;
        state_d = StErr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized scoreboard bench: the driver walks each instruction through its
// expected phase sequence and queues per-cycle expectations for the monitor.
module tb_mips_multicycle_controller;
  import mips_pkg::*;

  localparam int unsigned Tmo = 4;

  typedef enum int {
    KRArith = 0, KSlt = 1, KJr = 2, KAddi = 3, KSlti = 4, KLw = 5,
    KSw = 6, KBeq = 7, KJ = 8, KJal = 9, KIll = 10
  } kind_e;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
    logic       reg_dst, jal, reg_write, mem_to_reg, slt, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       busy, err, pc_upd;
  } obs_t;

  logic        clk, rst_n, zero, mem_ready;
  logic [31:0] inst;
  logic        pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
  logic        reg_dst, jal, reg_write, mem_to_reg, slt, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        busy, err;
  logic [3:0]  state;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mips_multicycle_controller #(
    .INST_W      (32),
    .MEM_TIMEOUT (Tmo)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .jal           (jal),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .slt           (slt),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .busy          (busy),
    .err           (err),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what each phase must present, straight from the control table.
  function automatic obs_t expect_obs(state_e st, kind_e k, logic rdy, logic z);
    obs_t o;
    o       = '0;
    o.state = st;
    o.busy  = 1'b1;
    case (st)
      StFetch: begin
        o.mem_read = 1; o.alu_src_b = 2'd1; o.pc_src = 2'd1; o.busy = rdy;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      StDecode:  o.alu_src_b = 2'd3;
      StExR:     begin o.alu_src_a = 1; o.alu_src_b = 2'd0; o.alu_op = 2'd2; end
      StExI:     begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = (k == KSlti) ? 2'd1 : 2'd0; end
      StMemAddr: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      StMemRd:   begin o.iord = 1; o.mem_read = 1; end
      StMemWr:   begin o.iord = 1; o.mem_write = 1; end
      StWbR:     begin o.reg_dst = 1; o.reg_write = 1; o.slt = (k == KSlt); end
      StWbI:     begin o.reg_write = 1; o.slt = (k == KSlti); end
      StWbMem:   begin o.mem_to_reg = 1; o.reg_write = 1; end
      StBranch:  begin o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_write_cond = 1; end
      StJump: begin
        o.pc_write = 1; o.pc_src = (k == KJr) ? 2'd3 : 2'd2;
        o.jal = (k == KJal); o.reg_write = (k == KJal);
      end
      StErr:     o.err = 1;
      default:   o.err = 1;
    endcase
    o.pc_upd = o.pc_write | (o.pc_write_cond & z);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.state = state;         a.pc_write = pc_write;   a.pc_write_cond = pc_write_cond;
    a.iord = iord;           a.ir_write = ir_write;   a.mem_read = mem_read;
    a.mem_write = mem_write; a.reg_dst = reg_dst;     a.jal = jal;
    a.reg_write = reg_write; a.mem_to_reg = mem_to_reg; a.slt = slt;
    a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
    a.pc_src = pc_src;       a.busy = busy;           a.err = err;
    a.pc_upd = pc_write | (pc_write_cond & zero);
    return a;
  endfunction

  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = sample();
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL cycle_obs t=%0t got %h expected %h", $time, a, e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic drive_cycle(input state_e st, input kind_e k, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(expect_obs(st, k, rdy, z));
    @(posedge clk);
    #1;
  endtask

  // Wait phase: `stalls` not-ready cycles, then ready, unless the limit runs out.
  task automatic mem_phase(input state_e st, input kind_e k, input int stalls, input logic z,
                           output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < stalls && !timed_out; i++) begin
      drive_cycle(st, k, 1'b0, z);
      if (i + 1 >= int'(Tmo)) timed_out = 1'b1;
    end
    if (!timed_out) drive_cycle(st, k, 1'b1, z);
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(StFetch));
    check("rst_err", 32'(err), 0);
    check("rst_mem_read_busy", {mem_read, busy}, 32'b10);
    check("rst_strobes", {pc_write, ir_write, reg_write, mem_write}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic err_tail();
    for (int i = 0; i < 3; i++) drive_cycle(StErr, KIll, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
  endtask

  function automatic logic [31:0] make_inst(kind_e k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  f;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 3))
      0: f = 6'h20;
      1: f = 6'h22;
      2: f = 6'h24;
      default: f = 6'h25;
    endcase
    case (k)
      KRArith: return {6'h00, rs, rt, rd, 5'd0, f};
      KSlt:    return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      KJr:     return {6'h00, rs, 15'd0, 6'h08};
      KAddi:   return {6'h08, rs, rt, imm};
      KSlti:   return {6'h0A, rs, rt, imm};
      KLw:     return {6'h23, rs, rt, imm};
      KSw:     return {6'h2B, rs, rt, imm};
      KBeq:    return {6'h04, rs, rt, imm};
      KJ:      return {6'h02, rs, rt, imm};
      KJal:    return {6'h03, rs, rt, imm};
      default: begin
        case ($urandom_range(0, 2))
          0: return {6'h3F, rs, rt, imm};
          1: return {6'h05, rs, rt, imm};
          default: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
        endcase
      end
    endcase
  endfunction

  task automatic run_instr(input kind_e k, input logic [31:0] w, input int fst, input int mst,
                           input logic z);
    bit to;
    inst = w;
    mem_phase(StFetch, k, fst, z, to);
    if (to) begin err_tail(); return; end
    drive_cycle(StDecode, k, 1'($urandom_range(0, 1)), z);
    case (k)
      KRArith, KSlt: begin
        drive_cycle(StExR, k, 1'($urandom_range(0, 1)), z);
        drive_cycle(StWbR, k, 1'($urandom_range(0, 1)), z);
      end
      KAddi, KSlti: begin
        drive_cycle(StExI, k, 1'($urandom_range(0, 1)), z);
        drive_cycle(StWbI, k, 1'($urandom_range(0, 1)), z);
      end
      KLw: begin
        drive_cycle(StMemAddr, k, 1'($urandom_range(0, 1)), z);
        mem_phase(StMemRd, k, mst, z, to);
        if (to) err_tail();
        else drive_cycle(StWbMem, k, 1'($urandom_range(0, 1)), z);
      end
      KSw: begin
        drive_cycle(StMemAddr, k, 1'($urandom_range(0, 1)), z);
        mem_phase(StMemWr, k, mst, z, to);
        if (to) err_tail();
      end
      KBeq:         drive_cycle(StBranch, k, 1'($urandom_range(0, 1)), z);
      KJ, KJal, KJr: drive_cycle(StJump, k, 1'($urandom_range(0, 1)), z);
      default:      err_tail();
    endcase
  endtask

  function automatic int rand_stall();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return int'(Tmo) + int'($urandom_range(0, 1));
    if (r < 7) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  initial begin
    rst_n     = 1'b0;
    inst      = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #3;
    check("init_state", 32'(state), 32'(StFetch));
    check("init_mem_read", 32'(mem_read), 1);
    check("init_err_busy", {err, busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(KRArith, 32'h0022_1820, 0, 0, 1'b0);
    run_instr(KLw,     32'h8C22_0004, 0, 3, 1'b0);
    run_instr(KBeq,    32'h1022_0003, 0, 0, 1'b0);
    run_instr(KBeq,    32'h1022_0003, 0, 0, 1'b1);
    run_instr(KJal,    32'h0C00_0010, 0, 0, 1'b0);
    run_instr(KJr,     32'h03E0_0008, 0, 0, 1'b0);
    run_instr(KSlti,   32'h2822_0005, 3, 0, 1'b0);
    run_instr(KSw,     32'hAC22_0008, 0, 3, 1'b0);
    run_instr(KRArith, 32'h0022_1820, int'(Tmo), 0, 1'b0);
    run_instr(KIll,    32'hFC00_0000, 0, 0, 1'b0);

    // Reset asserted while a store is stalled must drop mem_write at once.
    inst = 32'hAC22_0008;
    drive_cycle(StFetch, KSw, 1'b1, 1'b0);
    drive_cycle(StDecode, KSw, 1'b1, 1'b0);
    drive_cycle(StMemAddr, KSw, 1'b0, 1'b0);
    mem_ready = 1'b0;
    exp_q.push_back(expect_obs(StMemWr, KSw, 1'b0, 1'b0));
    #6;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", 32'(mem_write), 0);
    check("async_rst_state", 32'(state), 32'(StFetch));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(KRArith, 32'h0022_1820, 3, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      kind_e k;
      k = kind_e'($urandom_range(0, 10));
      run_instr(k, make_inst(k), rand_stall(), rand_stall(), 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
